solver_run_monitor: RTL and testbench
=====================================

Name: solver_run_monitor

Overview:
Synthesizable, parametrised run monitor for puzzle solvers. It supervises NUM_CH solver instances through their Done/Error/Result outputs. It timestamps each channel's completion, checks captured results against expected values, applies a watchdog timeout, and reports one PASS/FAIL verdict. It sits in Top between the solver instances and the board/sim status pins, replacing ad-hoc bench-side Done/Error watching.

Parameters:
NUM_CH, 2, number of supervised solver channels (1..16)
RESULT_W, 64, width of each channel result (e.g. InvalidIdSum)
CNT_W, 32, width of the run cycle counter and per-channel latency stamps
TIMEOUT_CYC, 1000000, watchdog limit in cycles after Start; 0 disables the watchdog

Ports:
Clk  in  1  single clock; all logic on posedge
Rst  in  1  synchronous, active-high reset
Start  in  1  one-cycle pulse; begins a run from IDLE, PASS or FAIL
ChDone  in  NUM_CH  per-channel done level from each solver
ChError  in  NUM_CH  per-channel error level from each solver
ChResult  in  NUM_CH*RESULT_W  per-channel result; channel i at bits [i*RESULT_W +: RESULT_W]
ExpResult  in  NUM_CH*RESULT_W  expected results, same packing
ExpValid  in  NUM_CH  per-channel enable for the result compare
Busy  out  1  high in RUN and CHECK
Finished  out  1  high in PASS or FAIL
Pass  out  1  high in PASS
Fail  out  1  high in FAIL
TimedOut  out  1  sticky; watchdog expired in the current/last run
DoneMask  out  NUM_CH  sticky; channel has completed
ErrMask  out  NUM_CH  sticky; channel raised Error
MismatchMask  out  NUM_CH  channel result differed from expected (only where ExpValid)
CycleCount  out  CNT_W  cycles since Start; saturates at all-ones
ReadSel  in  $clog2(NUM_CH) or 1  channel select for the readback
ReadResult  out  RESULT_W  captured result of channel ReadSel (combinational mux)
ReadLatency  out  CNT_W  CycleCount value captured at ReadSel's completion

Behaviour:
- Reset state: IDLE. All outputs 0, all captured results, latency stamps and masks cleared. Rst wins over every other input in the same cycle; reset mid-run aborts with no verdict.
- States and transitions:
  - IDLE: Start -> RUN.
  - RUN: the transition is evaluated each cycle on the current inputs.
  - CHECK: one cycle; computes MismatchMask, then -> FAIL if any bit is set, else -> PASS.
  - PASS / FAIL: hold until Start (-> RUN) or Rst.
- Entering RUN (edge of Start): CycleCount, masks, TimedOut, captured results and stamps all clear to 0. Start is ignored while in RUN or CHECK.
- RUN counter: CycleCount increments by 1 per cycle in RUN, saturating. It freezes outside RUN.
- Channel completion: when ChDone[i]=1 and DoneMask[i]=0, capture ChResult[i] and the current CycleCount into channel i's registers and set DoneMask[i]. Later Done levels and result changes are ignored.
- Channel error: ChError[i]=1 in RUN sets ErrMask[i].
- RUN exit priority, highest first:
  1. Any ChError bit high this cycle -> FAIL.
  2. All channels done, counting this cycle's captures -> CHECK.
  3. TIMEOUT_CYC!=0 and CycleCount==TIMEOUT_CYC-1 -> FAIL with TimedOut=1.
- Same-cycle error and done on one channel: the result is still captured and DoneMask set; the verdict is FAIL.
- Compare: MismatchMask[i] = ExpValid[i] && captured[i] != ExpResult[i]. ExpResult and ExpValid are sampled in the CHECK cycle.
- Latency: Pass/Fail assert 2 cycles after the cycle in which the last Done is sampled (RUN->CHECK->PASS/FAIL). An error asserts Fail 1 cycle later.
- Outputs are registered, except ReadResult and ReadLatency. An out-of-range ReadSel returns 0.

Test Plan:
- Pass path: NUM_CH=2, TIMEOUT_CYC=100. Start at cycle 0; ChDone[0] at count 10 with result 1227775554, ChDone[1] at count 20 with result 4174379265; expected values equal, ExpValid=2'b11 -> Pass rises 2 cycles after ch1 Done. ReadLatency reads 10 and 20; MismatchMask=0.
- Mismatch: as above but ExpResult[1]=4174379264 -> Fail=1, MismatchMask=2'b10, TimedOut=0. With ExpValid=2'b01 instead -> Pass.
- Error priority: ChError[0] and the final ChDone[1] asserted in the same cycle -> Fail next cycle, ErrMask=2'b01, DoneMask[1]=1 with result captured.
- Timeout: TIMEOUT_CYC=100, only ch0 completes -> Fail and TimedOut at CycleCount=99, DoneMask=2'b01. With TIMEOUT_CYC=0, no verdict after 10000 cycles; Busy stays high.
- Sticky capture: ChDone[0] held high while ChResult[0] changes 5 -> 9 -> captured value stays 5. Start pulsed in RUN -> ignored; Start in PASS -> all state cleared and a new run begins.
- Reset mid-run: Rst at CycleCount=50 -> next cycle IDLE, all outputs 0. Rst together with Start -> remains IDLE.

Source files
------------

// File: rtl/solver_run_monitor.sv
// Run monitor for a bank of puzzle solvers: timestamps each channel's completion,
// checks captured results, applies a watchdog and reports one PASS/FAIL verdict.
module solver_run_monitor #(
  parameter int NUM_CH      = 2,
  parameter int RESULT_W    = 64,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Start,
  input  logic [NUM_CH-1:0]          ChDone,
  input  logic [NUM_CH-1:0]          ChError,
  input  logic [NUM_CH*RESULT_W-1:0] ChResult,
  input  logic [NUM_CH*RESULT_W-1:0] ExpResult,
  input  logic [NUM_CH-1:0]          ExpValid,
  output logic                       Busy,
  output logic                       Finished,
  output logic                       Pass,
  output logic                       Fail,
  output logic                       TimedOut,
  output logic [NUM_CH-1:0]          DoneMask,
  output logic [NUM_CH-1:0]          ErrMask,
  output logic [NUM_CH-1:0]          MismatchMask,
  output logic [CNT_W-1:0]           CycleCount,
  input  logic [SEL_W-1:0]           ReadSel,
  output logic [RESULT_W-1:0]        ReadResult,
  output logic [CNT_W-1:0]           ReadLatency
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_PASS, S_FAIL} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;

  logic [RESULT_W-1:0] cap_res_p0 [NUM_CH];
  logic [CNT_W-1:0]    cap_lat_p0 [NUM_CH];
  logic [NUM_CH-1:0]   mismatch_d;
  logic                all_done;
  logic                timeout_hit;
  logic                run_entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Completion counts this cycle's Done levels so the last capture and exit coincide
  assign all_done    = &(DoneMask | ChDone);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (CycleCount == TO_LAST);
  assign run_entry   = (state_q != S_RUN) && (state_d == S_RUN);

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: if (Start) state_d = S_RUN;
      S_RUN: begin
        if (|ChError)         state_d = S_FAIL;
        else if (all_done)    state_d = S_CHECK;
        else if (timeout_hit) state_d = S_FAIL;
      end
      S_CHECK: state_d = (|mismatch_d) ? S_FAIL : S_PASS;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy     = (state_q == S_RUN) || (state_q == S_CHECK);
    Finished = (state_q == S_PASS) || (state_q == S_FAIL);
    Pass     = (state_q == S_PASS);
    Fail     = (state_q == S_FAIL);
  end

  always_comb begin
    mismatch_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      mismatch_d[i] = ExpValid[i] && (cap_res_p0[i] != ExpResult[i*RESULT_W +: RESULT_W]);
  end

  // Capture stage: per-channel result/latency stamps, sticky masks and run counter
  always_ff @(posedge Clk) begin
    if (Rst || run_entry) begin
      CycleCount   <= '0;
      DoneMask     <= '0;
      ErrMask      <= '0;
      MismatchMask <= '0;
      TimedOut     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cap_res_p0[i] <= '0;
        cap_lat_p0[i] <= '0;
      end
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ChDone[i] && !DoneMask[i]) begin
          cap_res_p0[i] <= ChResult[i*RESULT_W +: RESULT_W];
          cap_lat_p0[i] <= CycleCount;
          DoneMask[i]   <= 1'b1;
        end
      end
      ErrMask <= ErrMask | ChError;
      if (state_d == S_RUN) CycleCount <= sat_inc(CycleCount);
      if (!(|ChError) && !all_done && timeout_hit) TimedOut <= 1'b1;
    end else if (state_q == S_CHECK) begin
      MismatchMask <= mismatch_d;
    end
  end

  always_comb begin
    ReadResult  = '0;
    ReadLatency = '0;
    if (int'(ReadSel) < NUM_CH) begin
      ReadResult  = cap_res_p0[ReadSel];
      ReadLatency = cap_lat_p0[ReadSel];
    end
  end

endmodule

// File: tb/tb_solver_run_monitor.sv
// Bench for solver_run_monitor: run-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_solver_run_monitor;
  localparam int NUM_CH = 2;
  localparam int RW     = 64;
  localparam int CW     = 32;
  localparam int TO     = 100;

  localparam int P_IDLE = 0, P_RUN = 1, P_CHK = 2, P_PASS = 3, P_FAIL = 4;

  logic           Clk = 1'b0;
  logic           Rst = 1'b0;
  logic           Start = 1'b0;
  logic [1:0]     ChDone = '0, ChError = '0, ExpValid = '0;
  logic [2*RW-1:0] ChResult = '0, ExpResult = '0;
  logic [0:0]     ReadSel = '0;

  logic           Busy, Finished, Pass, Fail, TimedOut;
  logic [1:0]     DoneMask, ErrMask, MismatchMask;
  logic [CW-1:0]  CycleCount, ReadLatency;
  logic [RW-1:0]  ReadResult;

  logic           z_Busy, z_Finished, z_Pass, z_Fail, z_TimedOut;
  logic [1:0]     z_DoneMask, z_ErrMask, z_MismatchMask;
  logic [CW-1:0]  z_CycleCount, z_ReadLatency;
  logic [RW-1:0]  z_ReadResult;

  solver_run_monitor #(.NUM_CH(NUM_CH), .RESULT_W(RW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ChDone(ChDone), .ChError(ChError),
    .ChResult(ChResult), .ExpResult(ExpResult), .ExpValid(ExpValid),
    .Busy(Busy), .Finished(Finished), .Pass(Pass), .Fail(Fail), .TimedOut(TimedOut),
    .DoneMask(DoneMask), .ErrMask(ErrMask), .MismatchMask(MismatchMask),
    .CycleCount(CycleCount), .ReadSel(ReadSel), .ReadResult(ReadResult),
    .ReadLatency(ReadLatency));

  solver_run_monitor #(.NUM_CH(NUM_CH), .RESULT_W(RW), .CNT_W(CW), .TIMEOUT_CYC(0)) dut_nowd (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ChDone(ChDone), .ChError(ChError),
    .ChResult(ChResult), .ExpResult(ExpResult), .ExpValid(ExpValid),
    .Busy(z_Busy), .Finished(z_Finished), .Pass(z_Pass), .Fail(z_Fail), .TimedOut(z_TimedOut),
    .DoneMask(z_DoneMask), .ErrMask(z_ErrMask), .MismatchMask(z_MismatchMask),
    .CycleCount(z_CycleCount), .ReadSel(ReadSel), .ReadResult(z_ReadResult),
    .ReadLatency(z_ReadLatency));

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of one run, in terms of run phase and elapsed cycles
  int          ph = P_IDLE;
  bit          mv = 1'b0;
  logic [31:0] mcnt;
  logic [1:0]  mdone, merr, mmm;
  bit          mto;
  logic [63:0] mres [2];
  logic [31:0] mlat [2];

  task automatic clear_model();
    mcnt = '0; mdone = '0; merr = '0; mmm = '0; mto = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mres[i] = '0;
      mlat[i] = '0;
    end
  endtask

  task automatic step_model();
    if (Rst) begin
      ph = P_IDLE;
      mv = 1'b1;
      clear_model();
    end else begin
      case (ph)
        P_IDLE, P_PASS, P_FAIL: if (Start) begin clear_model(); ph = P_RUN; end
        P_RUN: begin
          for (int i = 0; i < 2; i++)
            if (ChDone[i] && !mdone[i]) begin
              mdone[i] = 1'b1;
              mres[i]  = ChResult[i*RW +: RW];
              mlat[i]  = mcnt;
            end
          merr = merr | ChError;
          if (ChError != 2'b00) ph = P_FAIL;
          else if (mdone == 2'b11) ph = P_CHK;
          else if (mcnt == 32'(TO - 1)) begin ph = P_FAIL; mto = 1'b1; end
          else if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
        end
        P_CHK: begin
          for (int i = 0; i < 2; i++)
            mmm[i] = ExpValid[i] && (mres[i] != ExpResult[i*RW +: RW]);
          ph = (mmm != 2'b00) ? P_FAIL : P_PASS;
        end
        default: ph = P_IDLE;
      endcase
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge sees
  initial forever begin
    @(negedge Clk);
    if (mv) begin
      chk("busy",     64'(Busy),     64'(ph == P_RUN || ph == P_CHK));
      chk("finished", 64'(Finished), 64'(ph == P_PASS || ph == P_FAIL));
      chk("pass",     64'(Pass),     64'(ph == P_PASS));
      chk("fail",     64'(Fail),     64'(ph == P_FAIL));
      chk("timedout", 64'(TimedOut), 64'(mto));
      chk("donemask", 64'(DoneMask), 64'(mdone));
      chk("errmask",  64'(ErrMask),  64'(merr));
      chk("mismatch", 64'(MismatchMask), 64'(mmm));
      chk("cyclecount", 64'(CycleCount), 64'(mcnt));
      chk("readresult", ReadResult, mres[ReadSel]);
      chk("readlatency", 64'(ReadLatency), 64'(mlat[ReadSel]));
    end
    step_model();
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      ReadSel = ~ReadSel;
    end
  endtask

  task automatic set_res(input int ch, input logic [63:0] v);
    ChResult[ch*RW +: RW] = v;
  endtask

  task automatic set_exp(input int ch, input logic [63:0] v);
    ExpResult[ch*RW +: RW] = v;
  endtask

  task automatic do_reset();
    Rst = 1'b1; Start = 1'b0; ChDone = '0; ChError = '0;
    tick(1);
    Rst = 1'b0;
  endtask

  task automatic start_run();
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic run_two(input logic [63:0] e1, input logic [1:0] ev,
                         input bit exp_pass, input logic [1:0] exp_mm);
    do_reset();
    set_exp(0, 64'd1227775554);
    set_exp(1, e1);
    ExpValid = ev;
    start_run();
    tick(10);
    set_res(0, 64'd1227775554); ChDone[0] = 1'b1;
    tick(10);
    set_res(1, 64'd4174379265); ChDone[1] = 1'b1;
    tick(1);
    chk("lit_check_busy", 64'(Busy), 64'd1);
    chk("lit_check_not_fin", 64'(Finished), 64'd0);
    tick(1);
    chk("lit_pass", 64'(Pass), 64'(exp_pass));
    chk("lit_fail", 64'(Fail), 64'(!exp_pass));
    chk("lit_mm", 64'(MismatchMask), 64'(exp_mm));
    chk("lit_to", 64'(TimedOut), 64'd0);
    chk("lit_count", 64'(CycleCount), 64'd20);
    ReadSel = 1'b0; #1;
    chk("lit_lat0", 64'(ReadLatency), 64'd10);
    chk("lit_res0", ReadResult, 64'd1227775554);
    ReadSel = 1'b1; #1;
    chk("lit_lat1", 64'(ReadLatency), 64'd20);
    chk("lit_res1", ReadResult, 64'd4174379265);
  endtask

  initial begin
    do_reset();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_fin", 64'(Finished), 64'd0);
    chk("rst_count", 64'(CycleCount), 64'd0);
    chk("rst_done", 64'(DoneMask), 64'd0);

    // Pass path, mismatch, and mismatch masked by ExpValid
    run_two(64'd4174379265, 2'b11, 1'b1, 2'b00);
    run_two(64'd4174379264, 2'b11, 1'b0, 2'b10);
    run_two(64'd4174379264, 2'b01, 1'b1, 2'b00);

    // Error and final Done in the same cycle
    do_reset();
    start_run();
    tick(5);
    set_res(0, 64'd111); ChDone[0] = 1'b1;
    tick(5);
    set_res(1, 64'd222); ChDone[1] = 1'b1; ChError = 2'b01;
    tick(1);
    chk("err_fail", 64'(Fail), 64'd1);
    chk("err_mask", 64'(ErrMask), 64'd1);
    chk("err_done", 64'(DoneMask), 64'd3);
    chk("err_to", 64'(TimedOut), 64'd0);
    ReadSel = 1'b1; #1;
    chk("err_res1", ReadResult, 64'd222);

    // Watchdog expiry with only channel 0 complete
    do_reset();
    start_run();
    tick(3);
    set_res(0, 64'd42); ChDone[0] = 1'b1;
    tick(96);
    chk("to_pre_fail", 64'(Fail), 64'd0);
    chk("to_pre_busy", 64'(Busy), 64'd1);
    tick(1);
    chk("to_fail", 64'(Fail), 64'd1);
    chk("to_flag", 64'(TimedOut), 64'd1);
    chk("to_count", 64'(CycleCount), 64'd99);
    chk("to_done", 64'(DoneMask), 64'd1);

    // Watchdog disabled: instance without timeout keeps running
    do_reset();
    start_run();
    ChDone[0] = 1'b1;
    tick(10000);
    chk("nowd_busy", 64'(z_Busy), 64'd1);
    chk("nowd_fin", 64'(z_Finished), 64'd0);
    chk("nowd_to", 64'(z_TimedOut), 64'd0);
    chk("nowd_count", 64'(z_CycleCount), 64'd10000);
    chk("nowd_done", 64'(z_DoneMask), 64'd1);

    // Sticky capture, Start ignored in RUN, Start from PASS restarts
    do_reset();
    ExpValid = 2'b00;
    start_run();
    set_res(0, 64'd5); ChDone[0] = 1'b1;
    tick(1);
    set_res(0, 64'd9);
    tick(2);
    start_run();
    chk("sticky_count", 64'(CycleCount), 64'd4);
    chk("sticky_busy", 64'(Busy), 64'd1);
    ReadSel = 1'b0; #1;
    chk("sticky_res0", ReadResult, 64'd5);
    chk("sticky_lat0", 64'(ReadLatency), 64'd0);
    set_res(1, 64'd7); ChDone[1] = 1'b1;
    tick(2);
    chk("sticky_pass", 64'(Pass), 64'd1);
    start_run();
    chk("restart_done", 64'(DoneMask), 64'd0);
    chk("restart_count", 64'(CycleCount), 64'd0);
    chk("restart_busy", 64'(Busy), 64'd1);
    chk("restart_pass", 64'(Pass), 64'd0);
    ReadSel = 1'b0; #1;
    chk("restart_res0", ReadResult, 64'd0);
    ChDone = '0;
    tick(3);

    // Reset mid-run, and reset together with Start
    do_reset();
    start_run();
    tick(50);
    chk("mid_count", 64'(CycleCount), 64'd50);
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    chk("mid_busy", 64'(Busy), 64'd0);
    chk("mid_fin", 64'(Finished), 64'd0);
    chk("mid_count0", 64'(CycleCount), 64'd0);
    Rst = 1'b1; Start = 1'b1;
    tick(1);
    Rst = 1'b0; Start = 1'b0;
    tick(1);
    chk("rststart_busy", 64'(Busy), 64'd0);
    chk("rststart_count", 64'(CycleCount), 64'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
